// File: rtl/alu_exec.sv
// Multi-cycle RV32I execution ALU. Logic, add/sub and compares finish in one
// cycle; shifts walk one bit position per cycle so no barrel shifter is built.
// One operation in flight at a time, valid/ready on both sides.
module alu_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b10000;
    localparam logic [4:0] OP_AND  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b10111;
    localparam logic [4:0] OP_SLTU = 5'b11000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [4:0]      ctrl_reg, ctrl_next;
    logic [XLEN-1:0] shreg_reg, shreg_next;
    logic [SHW-1:0]  cnt_reg, cnt_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic            zero_reg, zero_next;
    logic            illegal_reg, illegal_next;

    // Single-cycle results, computed straight from the offered operands
    logic [XLEN-1:0] fast_res;
    logic            fast_ill;
    logic            is_shift;
    logic [SHW-1:0]  sh_amt;

    assign sh_amt = op_b[SHW-1:0];

    // Decode and evaluate every one-cycle operation
    always_comb begin
        fast_res = '0;
        fast_ill = 1'b0;
        is_shift = 1'b0;
        case (alu_ctrl)
            OP_ADD:  fast_res = op_a + op_b;
            OP_SUB:  fast_res = op_a - op_b;
            OP_AND:  fast_res = op_a & op_b;
            OP_OR:   fast_res = op_a | op_b;
            OP_XOR:  fast_res = op_a ^ op_b;
            OP_SLL, OP_SRL, OP_SRA: begin
                // A zero-length shift completes immediately with op_a unchanged
                is_shift = 1'b1;
                fast_res = op_a;
            end
            OP_SLT:  fast_res = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: fast_res = XLEN'(op_a < op_b);
            default: fast_ill = 1'b1;
        endcase
    end

    // One-bit shift step of the working register, left and right variants
    logic [XLEN-1:0] shl_one;
    logic [XLEN-1:0] shr_one;
    logic [XLEN-1:0] shift_step;
    logic            right_fill;

    assign right_fill = (ctrl_reg == OP_SRA) ? shreg_reg[XLEN-1] : 1'b0;

    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign shl_one[gi] = 1'b0;
            end else begin : g_lmid
                assign shl_one[gi] = shreg_reg[gi-1];
            end
            if (gi == XLEN-1) begin : g_msb
                assign shr_one[gi] = right_fill;
            end else begin : g_rmid
                assign shr_one[gi] = shreg_reg[gi+1];
            end
        end
    endgenerate

    assign shift_step = (ctrl_reg == OP_SLL) ? shl_one : shr_one;

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence
    always_comb begin
        state_next   = state_reg;
        ctrl_next    = ctrl_reg;
        shreg_next   = shreg_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;
        zero_next    = zero_reg;
        illegal_next = illegal_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    ctrl_next = alu_ctrl;
                    if (is_shift && (sh_amt != '0)) begin
                        shreg_next   = op_a;
                        cnt_next     = sh_amt;
                        result_next  = '0;
                        zero_next    = 1'b0;
                        illegal_next = 1'b0;
                        state_next   = S_SHIFT;
                    end else begin
                        result_next  = fast_res;
                        zero_next    = (fast_res == '0);
                        illegal_next = fast_ill;
                        state_next   = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                shreg_next = shift_step;
                cnt_next   = cnt_reg - SHW'(1);
                if (cnt_reg == SHW'(1)) begin
                    result_next  = shift_step;
                    zero_next    = (shift_step == '0);
                    illegal_next = 1'b0;
                    state_next   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: captured op, shift working value, counter, outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg    <= '0;
            shreg_reg   <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            ctrl_reg    <= ctrl_next;
            shreg_reg   <= shreg_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
            zero_reg    <= zero_next;
            illegal_reg <= illegal_next;
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign illegal   = illegal_reg;

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Multi-cycle RV32I execution ALU. It is the consumer of the 5-bit alu_ctrl code produced by the ALU decoder.
- It accepts one operation per valid/ready handshake, computes it, and returns the result with branch flags through an output valid/ready handshake.
- Logic ops, add/sub and compares take one cycle. Shifts are iterative, one bit per cycle, so no barrel shifter is needed.
- Sits between the operand-select stage and writeback/branch-resolve in the CPU.

Parameters:
- XLEN, 32, operand and result width.
- SHW, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operation offered.
- in_ready  output  1  block can accept an operation.
- alu_ctrl  input  5  operation code (encodings below).
- op_a  input  XLEN  operand A (rs1/PC).
- op_b  input  XLEN  operand B (rs2/imm); op_b[SHW-1:0] is the shift amount.
- out_valid  output  1  result available.
- out_ready  input  1  downstream takes result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0; used for branch equality after SUB.
- illegal  output  1  alu_ctrl was not a defined code.

Behaviour:
- Opcode encodings:
  - 00000 ADD, 10000 SUB, 00001 AND, 00010 OR, 00011 XOR
  - 00100 SLL, 00101 SRL, 00110 SRA
  - 10111 SLT (signed), 11000 SLTU (unsigned)
- Any other code is illegal: result=0, illegal=1, one-cycle latency.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN; no carry/overflow output.
  - SLT/SLTU return 32'h0000_0001 or 32'h0000_0000.
  - Only op_b[SHW-1:0] is used for shifts; upper bits are ignored.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture alu_ctrl, op_a, op_b.
    - Non-shift op, or shift with amount 0: compute, go to DONE.
    - Shift with amount n>0: load op_a into the shift register and n into a down-counter, go to SHIFT.
  - SHIFT: each cycle shift one bit (SLL: <<1 zero-fill; SRL: >>1 zero-fill; SRA: >>1 sign-fill from current MSB) and decrement the counter. When the counter reaches 1, perform the last shift and go to DONE.
  - DONE: out_valid=1; result/zero/illegal are stable and held.
    - out_ready=1: go to IDLE next cycle.
    - out_ready=0: stay in DONE, outputs unchanged.
- in_ready is 1 only in IDLE. Inputs are ignored in SHIFT/DONE even if in_valid=1.
- Latency from acceptance edge to out_valid:
  - non-shift: 1 cycle
  - shift by n: n+1 cycles (n=0 → 1, n=31 → 32)
- Maximum throughput is one op per 2 cycles; there is no accept in the same cycle as result handoff.
- Captured operands are registered. Changes on op_a/op_b/alu_ctrl after acceptance do not affect the in-flight result.
- zero is computed from the final result and is valid only while out_valid=1.
- Reset (any state, including mid-SHIFT or DONE with a pending result) takes effect on the next edge:
  - state=IDLE; in-flight op discarded
  - in_ready=1, out_valid=0, result=0, zero=0, illegal=0
- The block has exactly one outstanding operation; nothing is buffered beyond it.

Test Plan:
- ADD/SUB with zero flag:
  - ADD op_a=32'h7FFF_FFFF, op_b=1 → out_valid 1 cycle after accept; result=32'h8000_0000, zero=0.
  - SUB 5-5 → result=0, zero=1.
- Compares:
  - SLT op_a=32'hFFFF_FFFF(-1), op_b=1 → result=1.
  - SLTU same operands → result=0.
- Shifts and latency:
  - SRA op_a=32'h8000_0000, op_b=32'h0000_0104 (amount 4) → result=32'hF800_0000; out_valid exactly 5 cycles after accept; in_ready=0 throughout.
  - SLL by 0 → result=op_a after 1 cycle.
  - SLL 1 by 31 → result=32'h8000_0000 after 32 cycles.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → result held, in_ready=0, new in_valid ignored. Assert out_ready → in_ready=1 the next cycle.
- Illegal code: alu_ctrl=5'b11111 → result=0, illegal=1, latency 1. The following legal AND (32'hF0F0_F0F0 & 32'h0FF0_0FF0 = 32'h00F0_00F0) has illegal=0.
- Reset mid-operation: SRL by 20, assert rst at cycle 7 → next cycle out_valid=0, in_ready=1, result=0. No stale result appears afterwards; a new ADD 2+3 returns 5.
